// File: rtl/chan_frame_packer.sv
// chan_frame_packer
// Round-robin arbiter plus byte serialiser. One pending channel word (data,
// status, channel id) is captured per frame and sent MSB byte first as
//   HDR, SEQ, {4'h0,CID}, STS, DW/8 data bytes, CHK
// on a byte-wide valid/ready stream.
// Optional feature macro: PACK_CRC8_EN. When it is defined, CHK is a CRC-8
// (poly 0x07, init 0, no reflection, no final xor) over SEQ..last data byte.
// When it is undefined, CHK is the modulo-256 sum of the same bytes.
module chan_frame_packer #(
  parameter int          NCH = 16,
  parameter int          DW  = 64,
  parameter logic [7:0]  HDR = 8'hA5
) (
  input  logic              fifo_clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH*8-1:0]  ch_stat,
  input  logic [NCH-1:0]    ch_vld,
  output logic [NCH-1:0]    ch_ack,
  output logic [7:0]        out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_sof,
  output logic              out_eof,
  output logic [15:0]       frm_cnt
);

  localparam int NB  = DW / 8;                    // data bytes per frame
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1; // data byte counter width
  localparam int CW  = 4;                         // channel id width

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEQ,
    S_CID,
    S_STS,
    S_DAT,
    S_CHK
  } state_t;

  state_t          state_reg;
  state_t          state_next;

  logic [DW-1:0]   ch_data_arr [NCH];
  logic [7:0]      ch_stat_arr [NCH];

  logic [CW-1:0]   grant;
  logic            grant_vld;
  logic            load;
  logic            accept;

  logic [CW-1:0]   rr_ptr_reg;
  logic [7:0]      seq_reg;
  logic [15:0]     frm_cnt_reg;
  logic [DW-1:0]   data_sh_reg;
  logic [7:0]      stat_reg;
  logic [CW-1:0]   cid_reg;
  logic [BCW-1:0]  byte_cnt_reg;
  logic [7:0]      chk_reg;
  logic [NCH-1:0]  ack_reg;

  // Unpack the flat channel buses into per-channel views.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_data_arr[gi] = ch_data[gi*DW +: DW];
      assign ch_stat_arr[gi] = ch_stat[gi*8 +: 8];
    end
  endgenerate

  // Running check value update for one accepted byte.
  function automatic logic [7:0] chk_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
`ifdef PACK_CRC8_EN
    r = c ^ b;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
`else
    r = c + b;
`endif
    return r;
  endfunction

  // Round-robin pick: first requesting channel at or after the pointer,
  // wrapping at NCH-1. Scanning offsets from high to low lets the smallest
  // offset win without a priority chain of found-flags.
  always_comb begin
    int idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      if (ch_vld[idx]) begin
        grant     = CW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge fifo_clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and stream outputs; outputs depend only on registered state so
  // the presented byte cannot change while the consumer is stalling.
  always_comb begin
    state_next = state_reg;
    out_vld    = 1'b0;
    out_sof    = 1'b0;
    out_eof    = 1'b0;
    out_data   = 8'h00;
    load       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (grant_vld) begin
          load       = 1'b1;
          state_next = S_HDR;
        end
      end
      S_HDR: begin
        out_vld  = 1'b1;
        out_sof  = 1'b1;
        out_data = HDR;
        if (out_rdy) state_next = S_SEQ;
      end
      S_SEQ: begin
        out_vld  = 1'b1;
        out_data = seq_reg;
        if (out_rdy) state_next = S_CID;
      end
      S_CID: begin
        out_vld  = 1'b1;
        out_data = {4'h0, cid_reg};
        if (out_rdy) state_next = S_STS;
      end
      S_STS: begin
        out_vld  = 1'b1;
        out_data = stat_reg;
        if (out_rdy) state_next = S_DAT;
      end
      S_DAT: begin
        out_vld  = 1'b1;
        out_data = data_sh_reg[DW-1 -: 8];
        if (out_rdy && (byte_cnt_reg == BCW'(NB - 1))) state_next = S_CHK;
      end
      S_CHK: begin
        out_vld  = 1'b1;
        out_eof  = 1'b1;
        out_data = chk_reg;
        if (out_rdy) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign accept = out_vld & out_rdy;

  // Capture the granted word, pulse its ack, and advance the frame datapath on
  // every accepted byte (check accumulation, data shift, sequence/frame count).
  always_ff @(posedge fifo_clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg   <= '0;
      seq_reg      <= '0;
      frm_cnt_reg  <= '0;
      data_sh_reg  <= '0;
      stat_reg     <= '0;
      cid_reg      <= '0;
      byte_cnt_reg <= '0;
      chk_reg      <= '0;
      ack_reg      <= '0;
    end else begin
      ack_reg <= '0;
      if (load) begin
        data_sh_reg  <= ch_data_arr[grant];
        stat_reg     <= ch_stat_arr[grant];
        cid_reg      <= grant;
        ack_reg      <= {{(NCH-1){1'b0}}, 1'b1} << grant;
        rr_ptr_reg   <= (grant == CW'(NCH - 1)) ? '0 : grant + 1'b1;
        chk_reg      <= '0;
        byte_cnt_reg <= '0;
      end
      if (accept) begin
        case (state_reg)
          S_SEQ, S_CID, S_STS: begin
            chk_reg <= chk_upd(chk_reg, out_data);
          end
          S_DAT: begin
            chk_reg      <= chk_upd(chk_reg, out_data);
            data_sh_reg  <= data_sh_reg << 8;
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
          end
          S_CHK: begin
            seq_reg     <= seq_reg + 8'd1;
            frm_cnt_reg <= frm_cnt_reg + 16'd1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ch_ack  = ack_reg;
  assign frm_cnt = frm_cnt_reg;

endmodule
